// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_pkg;

  localparam int DEFAULT_DIV = 2;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, duty decode and boundary-aligned divisor update.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             div_clk,
  output logic             tick,
  output logic             busy
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] deff;
  logic [DIV_W:0]   cnt_nxt;
  logic [DIV_W:0]   high;
  logic             pend_v;
  logic             run;
  logic             boundary;

  always_comb begin
    deff     = DIV_W'(clamp_div(32'(act_div)));
    high     = ({1'b0, deff} + ONE_X) >> 1;
    cnt_nxt  = {1'b0, cnt} + ONE_X;
    boundary = !run || (cnt == deff - ONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      act_div <= DIV_W'(RST_DIV);
      pend_v  <= 1'b0;
      run     <= 1'b0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      // Idle channel: a write lands directly, otherwise flush any pending value.
      cnt     <= '0;
      run     <= 1'b0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
      pend_v  <= 1'b0;
      if (wr)
        act_div <= wr_val;
      else if (pend_v)
        act_div <= pend_div;
    end else begin
      run <= 1'b1;
      if (boundary) begin
        cnt     <= '0;
        div_clk <= 1'b1;
        tick    <= 1'b1;
        if (pend_v) begin
          act_div <= pend_div;
          pend_v  <= 1'b0;
        end
      end else begin
        cnt     <= cnt_nxt[DIV_W-1:0];
        div_clk <= (cnt_nxt < high);
        tick    <= 1'b0;
      end
      // A write on a boundary edge is deferred to the next boundary.
      if (wr)
        pend_v <= 1'b1;
    end
  end

  // Pending value is pure data; its validity is tracked by pend_v.
  always_ff @(posedge clk) begin
    if (en && wr)
      pend_div <= wr_val;
  end

  assign busy = pend_v;

endmodule

// File: rtl/clock_divider_multi.sv
// N_CH independent programmable clock dividers sharing one reference clock.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int  N_CH        = 4,
  parameter int  DIV_W       = 16,
  parameter int  DEFAULT_DIV = clock_divider_pkg::DEFAULT_DIV,
  parameter int  NEG_EDGE    = 1,
  localparam int CH_W        = ch_width(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  en_i,
  input  logic             div_wr_i,
  input  logic [CH_W-1:0]  div_ch_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  tick_o,
  output logic [N_CH-1:0]  busy_o
);

  logic            act_clk;
  logic [N_CH-1:0] wr_ch;

  // Falling-edge operation is a static inversion of the reference clock.
  assign act_clk = (NEG_EDGE != 0) ? ~clk_i : clk_i;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    // Out-of-range channel numbers match no channel and are dropped.
    assign wr_ch[c] = div_wr_i && (div_ch_i == CH_W'(c));

    clock_divider_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (act_clk),
      .rst     (rst_i),
      .en      (en_i[c]),
      .wr      (wr_ch[c]),
      .wr_val  (div_val_i),
      .div_clk (clk_o[c]),
      .tick    (tick_o[c]),
      .busy    (busy_o[c])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: falling- and rising-edge builds side by side against a phase model.
module tb_clock_divider_multi;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          clk_b;
  logic          rst = 1'b0;
  logic [N-1:0]  en  = '0;
  logic          wr  = 1'b0;
  logic [1:0]    ch  = '0;
  logic [DW-1:0] val = '0;
  logic [N-1:0]  clk_n, tick_n, busy_n, clk_p, tick_p, busy_p;
  logic [2:0]    en3 = '0;
  logic          wr3 = 1'b0;
  logic [2:0]    clk3, tick3, busy3;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;
  assign clk_b = ~clk;

  // Both builds update at the same instant: falling clk == rising clk_b.
  clock_divider_multi #(.N_CH(N), .DIV_W(DW), .DEFAULT_DIV(2), .NEG_EDGE(1)) u_neg (
    .clk_i(clk), .rst_i(rst), .en_i(en), .div_wr_i(wr), .div_ch_i(ch), .div_val_i(val),
    .clk_o(clk_n), .tick_o(tick_n), .busy_o(busy_n));

  clock_divider_multi #(.N_CH(N), .DIV_W(DW), .DEFAULT_DIV(2), .NEG_EDGE(0)) u_pos (
    .clk_i(clk_b), .rst_i(rst), .en_i(en), .div_wr_i(wr), .div_ch_i(ch), .div_val_i(val),
    .clk_o(clk_p), .tick_o(tick_p), .busy_o(busy_p));

  // Three channels with a 2-bit select leaves channel number 3 out of range.
  clock_divider_multi #(.N_CH(3), .DIV_W(DW), .DEFAULT_DIV(2), .NEG_EDGE(1)) u_odd (
    .clk_i(clk), .rst_i(rst), .en_i(en3), .div_wr_i(wr3), .div_ch_i(ch), .div_val_i(val),
    .clk_o(clk3), .tick_o(tick3), .busy_o(busy3));

  // Model: position within the current period and the period length in force.
  int           m_act [N];
  int           m_pend[N];
  int           m_ph  [N];
  bit           m_pv  [N];
  logic [N-1:0] m_clk, m_tick, m_busy;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_act[c] = 2;
      m_pv[c]  = 1'b0;
      m_ph[c]  = -1;
    end
    m_clk  = '0;
    m_tick = '0;
    m_busy = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit w;
      int p;
      w = wr && (int'(ch) == c);
      if (!en[c]) begin
        if (w) m_act[c] = int'(val);
        else if (m_pv[c]) m_act[c] = m_pend[c];
        m_pv[c]   = 1'b0;
        m_ph[c]   = -1;
        m_clk[c]  = 1'b0;
        m_tick[c] = 1'b0;
      end else begin
        p = (m_act[c] < 2) ? 2 : m_act[c];
        if (m_ph[c] < 0 || m_ph[c] == p - 1) begin
          m_ph[c] = 0;
          if (m_pv[c]) m_act[c] = m_pend[c];
          m_pv[c] = 1'b0;
        end else begin
          m_ph[c] = m_ph[c] + 1;
        end
        m_tick[c] = (m_ph[c] == 0);
        m_clk[c]  = (m_ph[c] < (p + 1) / 2);
        if (w) begin
          m_pend[c] = int'(val);
          m_pv[c]   = 1'b1;
        end
      end
      m_busy[c] = m_pv[c];
    end
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      chk("model_clk_neg",  32'(clk_n),  32'(m_clk));
      chk("model_tick_neg", 32'(tick_n), 32'(m_tick));
      chk("model_busy_neg", 32'(busy_n), 32'(m_busy));
      chk("model_clk_pos",  32'(clk_p),  32'(m_clk));
      chk("model_tick_pos", 32'(tick_p), 32'(m_tick));
      chk("model_busy_pos", 32'(busy_p), 32'(m_busy));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed per-sample expectations for one channel; optional write at sample wi.
  task automatic pat(input string nm, input int c, input int n,
                     input logic [15:0] ce, input logic [15:0] te, input logic [15:0] be,
                     input int wi, input int wv);
    for (int i = 0; i < n; i++) begin
      chk({nm, "_clk_neg"},  32'(clk_n[c]),  32'(ce[i]));
      chk({nm, "_clk_pos"},  32'(clk_p[c]),  32'(ce[i]));
      chk({nm, "_tick_neg"}, 32'(tick_n[c]), 32'(te[i]));
      chk({nm, "_tick_pos"}, 32'(tick_p[c]), 32'(te[i]));
      chk({nm, "_busy_neg"}, 32'(busy_n[c]), 32'(be[i]));
      chk({nm, "_busy_pos"}, 32'(busy_p[c]), 32'(be[i]));
      if (i == wi) begin
        wr  = 1'b1;
        ch  = 2'(c);
        val = DW'(wv);
      end else begin
        wr = 1'b0;
      end
      cyc();
    end
    wr = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_clk",  32'({clk_n, clk_p, clk3}),    32'd0);
    chk("rst_tick", 32'({tick_n, tick_p, tick3}), 32'd0);
    chk("rst_busy", 32'({busy_n, busy_p, busy3}), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;

    // Default divisor on channel 0 only.
    en = 4'b0001;
    cyc();
    pat("d2", 0, 4, 16'b0101, 16'b0101, 16'b0, -1, 0);
    chk("idle_ch_low", 32'(clk_n[3:1]), 32'd0);

    // D=5 loaded while idle: high 3, low 2.
    wr = 1'b1; ch = 2'd1; val = 16'd5;
    cyc();
    wr = 1'b0; en[1] = 1'b1;
    cyc();
    pat("d5", 1, 10, 16'b0011100111, 16'b0000100001, 16'b0, -1, 0);

    // Channel 2 at D=4, rewritten to 6 mid-period.
    wr = 1'b1; ch = 2'd2; val = 16'd4;
    cyc();
    wr = 1'b0; en[2] = 1'b1;
    cyc();
    pat("d4to6", 2, 11, 16'b10001110011, 16'b10000010001, 16'b00000001100, 1, 6);

    // Write on a boundary edge of channel 0: one more period of 2, then 8.
    en[0] = 1'b0;
    cyc();
    en[0] = 1'b1;
    cyc();
    pat("bnd", 0, 13, 16'b1000011110101, 16'b1000000010101, 16'b0000000001100, 1, 8);

    // D=0 and D=1 run as D=2.
    wr = 1'b1; ch = 2'd3; val = 16'd0;
    cyc();
    wr = 1'b0; en[3] = 1'b1;
    cyc();
    pat("d0", 3, 4, 16'b0101, 16'b0101, 16'b0, -1, 0);
    en[3] = 1'b0; wr = 1'b1; ch = 2'd3; val = 16'd1;
    cyc();
    wr = 1'b0; en[3] = 1'b1;
    cyc();
    pat("d1", 3, 4, 16'b0101, 16'b0101, 16'b0, -1, 0);

    // Out-of-range channel select on the 3-channel build changes nothing.
    wr3 = 1'b1; ch = 2'd3; val = 16'd9;
    cyc();
    wr3 = 1'b0; en3 = 3'b111;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("oor_clk",  32'(clk3),  (i % 2 == 0) ? 32'd7 : 32'd0);
      chk("oor_tick", 32'(tick3), (i % 2 == 0) ? 32'd7 : 32'd0);
      chk("oor_busy", 32'(busy3), 32'd0);
      wr3 = (i == 1);
      cyc();
    end
    wr3 = 1'b0;

    // Asynchronous reset in the high phase of channel 1 with a write pending.
    en[1] = 1'b0;
    cyc();
    en[1] = 1'b1;
    cyc();
    wr = 1'b1; ch = 2'd1; val = 16'd7;
    cyc();
    wr = 1'b0;
    chk("pre_rst_high", 32'({clk_n[1], clk_p[1]}), 32'd3);
    chk("pre_rst_busy", 32'({busy_n[1], busy_p[1]}), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clk",  32'({clk_n, clk_p}),   32'd0);
    chk("async_rst_tick", 32'({tick_n, tick_p}), 32'd0);
    chk("async_rst_busy", 32'({busy_n, busy_p}), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    pat("post_rst", 1, 4, 16'b0101, 16'b0101, 16'b0, -1, 0);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
